// File: rtl/divider_unit.sv
// Sequential radix-2 restoring divider, one quotient bit per clock, with RISC-V M-extension
// handling of signed operands, divide-by-zero and signed overflow.
module divider_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_a;
  logic             r_sq;
  logic             r_sr;
  logic             r_dbz;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dbz_o;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_dq_next;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is correct as unsigned.
  assign w_a_neg = is_signed & a[WIDTH-1];
  assign w_b_neg = is_signed & b[WIDTH-1];
  assign w_abs_a = w_a_neg ? (~a + WIDTH'(1)) : a;
  assign w_abs_b = w_b_neg ? (~b + WIDTH'(1)) : b;

  // Two guard bits so an unsigned divisor near 2^WIDTH still yields a valid sign bit.
  assign w_rem_sh   = {r_rem, r_dq[WIDTH-1]};
  assign w_trial    = {1'b0, w_rem_sh} - {2'b00, r_div};
  assign w_ge       = ~w_trial[WIDTH+1];
  assign w_dq_next  = {r_dq[WIDTH-2:0], w_ge};
  assign w_rem_next = w_ge ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

  assign w_quot_fix = r_sq ? (~r_dq + WIDTH'(1)) : r_dq;
  assign w_rem_fix  = r_sr ? (~r_rem + WIDTH'(1)) : r_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_dq    <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_a     <= '0;
      r_sq    <= 1'b0;
      r_sr    <= 1'b0;
      r_dbz   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dbz_o <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_sq    <= w_a_neg ^ w_b_neg;
            r_sr    <= w_a_neg;
            r_dq    <= w_abs_a;
            r_div   <= w_abs_b;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_a     <= a;
            r_dbz   <= (b == '0);
            r_busy  <= 1'b1;
            // Divide-by-zero skips the iterations; FIX then publishes the fixed result.
            r_state <= (b == '0) ? StFix : StRun;
          end
        end
        StRun: begin
          r_dq  <= w_dq_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LastIter) r_state <= StFix;
        end
        StFix: begin
          r_quot  <= r_dbz ? '1 : w_quot_fix;
          r_remo  <= r_dbz ? r_a : w_rem_fix;
          r_dbz_o <= r_dbz;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= StDone;
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz_o;

endmodule

// File: tb/tb_divider_unit.sv
// Directed bench for divider_unit: a vector table of completed operations plus hand-written
// sequences for ignored restarts, start in the done cycle and mid-operation reset.
module tb_divider_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_cmp;
  int n_err;

  divider_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_signed  (is_signed),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] q;
    logic [31:0] r;
    bit          dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Issues a one-cycle start; returns at the falling edge after the accepting edge.
  task automatic issue(input bit sgn, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sgn;
    a         = va;
    b         = vb;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    while (!done && lat < 100) begin
      if (busy) bcyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bcyc;
    int dcount;
    logic [31:0] q_hold;

    n_cmp     = 0;
    n_err     = 0;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    reset     = 1'b0;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,        32'd14,        32'd2,        1'b0, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0, 33};
    vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1,        1'b0, 33};
    vecs[3]  = '{1'b1, 32'h12345678,  32'd0,        32'hFFFFFFFF,  32'h12345678, 1'b1, 1};
    vecs[4]  = '{1'b0, 32'h12345678,  32'd0,        32'hFFFFFFFF,  32'h12345678, 1'b1, 1};
    vecs[5]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000,  32'd0,        1'b0, 33};
    vecs[6]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF, 32'd0,         32'h80000000, 1'b0, 33};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF,  32'd0,        1'b0, 33};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'd1,         32'd0,        1'b0, 33};
    vecs[9]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE, 1'b0, 33};
    vecs[10] = '{1'b0, 32'd5,         32'd9,        32'd0,         32'd5,        1'b0, 33};
    vecs[11] = '{1'b0, 32'hFFFFFFFF,  32'h80000000, 32'd1,         32'h7FFFFFFF, 1'b0, 33};

    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].sgn, vecs[i].va, vecs[i].vb);
      wait_done(lat, bcyc);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), bcyc, vecs[i].lat);
      chk($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_quot", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_rem", i), remainder, vecs[i].r);
      chk($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
      q_hold = quotient;
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d_quot_hold", i), quotient, q_hold);
    end

    // Restart pulse while running must not disturb the latched 100/7.
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    start = 1'b1;
    a     = 32'd9;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcyc);
    chk("ign_lat", lat + 10, 33);
    chk("ign_quot", quotient, 32'd14);
    chk("ign_rem", remainder, 32'd2);
    issue(1'b0, 32'd9, 32'd3);
    wait_done(lat, bcyc);
    chk("after_quot", quotient, 32'd3);
    chk("after_rem", remainder, 32'd0);

    // Start held from the done cycle: ignored in DONE, accepted one cycle later.
    start     = 1'b1;
    is_signed = 1'b0;
    a         = 32'd50;
    b         = 32'd5;
    @(negedge clk);
    chk("done_start_ignored", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("done_start_next", {31'd0, busy}, 32'd1);
    wait_done(lat, bcyc);
    chk("done_start_lat", lat, 33);
    chk("done_start_quot", quotient, 32'd10);

    // Asynchronous reset in the middle of an operation.
    issue(1'b0, 32'd100, 32'd7);
    repeat (15) @(negedge clk);
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_quot", quotient, 32'd0);
    chk("mid_rst_rem", remainder, 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("mid_no_done", dcount, 0);
    issue(1'b0, 32'd50, 32'd5);
    wait_done(lat, bcyc);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_quot", quotient, 32'd10);
    chk("post_rst_rem", remainder, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
